control_unit_fsm: RTL and testbench
===================================

CONTROL_UNIT_FSM -- requirements
Module: control_unit_fsm

Interface
REQ-001 SHALL have port: CLK  input  1  single system clock; all state changes on its rising edge.
REQ-002 SHALL have port: Reset  input  1  synchronous, active-high reset, sampled on rising CLK.
REQ-003 SHALL have port: Opcode  input  5  IR[4:0] from the datapath, valid from DECODE onward.
REQ-004 SHALL have port: Overflow  input  1  datapath ALU overflow flag.
REQ-005 SHALL have ports, all outputs, widths as named: ALUOp 2, ALUSrcA 2, ALUSrcB 2, MemtoReg 2, RegWrite 1, MemRead 1, MemWrite 1, IorD 2, IRWrite 1, PCWrite 1, Jump 1, Branch 2, shouldBranch 1, RegFileSrc 2, ReturnSrc 3, DataSrc 2, OperandSrc 2, SPWrite 1; each drives the same-named datapath control input.
REQ-006 SHALL have port: State  output  4  current state encoding, for debug.
REQ-007 SHALL have port: Halted  output  1  high while in HALT.

Function
REQ-008 SHALL be a Moore FSM; every output is a function of the state register only, registered-state decode, no combinational path from Opcode to outputs.
REQ-009 SHALL use the following state encodings: FETCH=0, DECODE=1, ALU_EXEC=2, ALU_WB=3, MEM_ADDR=4, MEM_RD=5, MEM_WB=6, MEM_WR=7, BRANCH=8, JUMP=9, HALT=10; codes 11-15 are unused.
REQ-010 Outputs not listed for a state SHALL be 0.
REQ-011 FETCH SHALL assert MemRead=1, IorD=00, IRWrite=1, ALUSrcA=00 (PC), ALUSrcB=01 (+2), ALUOp=00 (add), PCWrite=1; next state is always DECODE.
REQ-012 DECODE SHALL assert ALUSrcA=00, ALUSrcB=11 (imm), ALUOp=00 to precompute the branch target. Next state:
- Opcode 00000-00111 goes to ALU_EXEC.
- 01000 (load) and 01001 (store) go to MEM_ADDR.
- 01010 (beq) and 01011 (bne) go to BRANCH.
- 01100 goes to JUMP.
- 11111 goes to HALT.
- Any other opcode is illegal (see REQ-022).
REQ-013 ALU_EXEC SHALL assert ALUSrcA=01 (A), ALUSrcB=00 (B), ALUOp=10 (funct from opcode); next state is ALU_WB.
REQ-014 ALU_WB SHALL assert RegWrite=1, MemtoReg=00 (ALUOut), RegFileSrc=00; next state is FETCH.
REQ-015 MEM_ADDR SHALL assert ALUSrcA=01, ALUSrcB=11, ALUOp=00. Next state is MEM_RD for load and MEM_WR for store; the opcode is captured in DECODE and held.
REQ-016 MEM_RD SHALL assert MemRead=1 and IorD=01 (ALUOut); next state is MEM_WB.
REQ-017 MEM_WB SHALL assert RegWrite=1 and MemtoReg=01 (MDR); next state is FETCH.
REQ-018 MEM_WR SHALL assert MemWrite=1, IorD=01, DataSrc=01 (RegB); next state is FETCH.
REQ-019 BRANCH SHALL assert ALUSrcA=01, ALUSrcB=00, ALUOp=01 (sub) and shouldBranch=1. Branch SHALL be 01 for beq and 10 for bne. Next state is FETCH.
REQ-020 JUMP SHALL assert Jump=1 and PCWrite=1; next state is FETCH.
REQ-021 HALT SHALL assert Halted=1 with all control outputs 0; the FSM remains in HALT until Reset.
REQ-022 An illegal opcode in DECODE SHALL return to FETCH, i.e. act as a nop, unless REQ-026 applies.
REQ-023 While in ALU_EXEC, a sampled Overflow=1 SHALL NOT change the sequence; overflow handling is a datapath concern.
REQ-024 An unused state code SHALL transition to FETCH on the next edge with all outputs 0.
REQ-025 Instruction latency SHALL be:
- ALU instruction: 4 cycles.
- Load: 5 cycles.
- Store: 4 cycles.
- Branch: 3 cycles.
- Jump: 3 cycles.

Reset
REQ-026 Reset=1 at a rising CLK SHALL force state FETCH and clear the captured opcode, regardless of current state, including mid-instruction and HALT.
REQ-027 During the cycle after reset the outputs SHALL equal FETCH outputs; Reset has priority over every transition.

Configuration
REQ-028 Macro CTRL_ILLEGAL_TRAP_EN:
- When defined, the block SHALL have an extra output IllegalOp (1 bit).
- An illegal opcode in DECODE SHALL go to HALT.
- IllegalOp SHALL be set and SHALL remain high until Reset.
- When undefined, there is no IllegalOp port and REQ-022 nop behaviour applies.

Verification
REQ-029 Reset pulse, then release -> State=0, MemRead=1, IRWrite=1, PCWrite=1, ALUSrcB=01 in the first cycle.
REQ-030 Opcode=00011 -> State sequence 0,1,2,3,0; RegWrite=1 only in state 3.
REQ-031 Opcode=01000, then 01001 -> load sequence 0,1,4,5,6,0 with MemtoReg=01 in state 6; store sequence 0,1,4,7,0 with MemWrite=1 only in state 7.
REQ-032 Opcode=01011 -> sequence 0,1,8,0 with Branch=10 and shouldBranch=1 in state 8; Opcode=01100 -> 0,1,9,0 with Jump=1.
REQ-033 Opcode=11111 -> HALT held for 20 cycles with Halted=1; Reset asserted in state 5 (MEM_RD) -> State=0 on the next edge.
REQ-034 Opcode=10101 -> without the macro, sequence 0,1,0; with CTRL_ILLEGAL_TRAP_EN, State=10 and IllegalOp=1 until Reset.

Source files
------------

// File: rtl/control_unit_fsm.sv
// control_unit_fsm: multi-cycle Moore control unit. Sequences FETCH/DECODE and the
// per-class execute states, driving datapath controls from the state register alone.
// Optional feature: define CTRL_ILLEGAL_TRAP_EN to trap illegal opcodes into HALT and
// expose a sticky IllegalOp flag; otherwise an illegal opcode behaves as a nop.
module control_unit_fsm (
    input  logic       CLK,
    input  logic       Reset,
    input  logic [4:0] Opcode,
    input  logic       Overflow,
    output logic [1:0] ALUOp,
    output logic [1:0] ALUSrcA,
    output logic [1:0] ALUSrcB,
    output logic [1:0] MemtoReg,
    output logic       RegWrite,
    output logic       MemRead,
    output logic       MemWrite,
    output logic [1:0] IorD,
    output logic       IRWrite,
    output logic       PCWrite,
    output logic       Jump,
    output logic [1:0] Branch,
    output logic       shouldBranch,
    output logic [1:0] RegFileSrc,
    output logic [2:0] ReturnSrc,
    output logic [1:0] DataSrc,
    output logic [1:0] OperandSrc,
    output logic       SPWrite,
`ifdef CTRL_ILLEGAL_TRAP_EN
    output logic       IllegalOp,
`endif
    output logic [3:0] State,
    output logic       Halted
);

    typedef enum logic [3:0] {
        StFetch   = 4'd0,
        StDecode  = 4'd1,
        StAluExec = 4'd2,
        StAluWb   = 4'd3,
        StMemAddr = 4'd4,
        StMemRd   = 4'd5,
        StMemWb   = 4'd6,
        StMemWr   = 4'd7,
        StBranch  = 4'd8,
        StJump    = 4'd9,
        StHalt    = 4'd10
    } state_e;

    localparam logic [4:0] OpLoad  = 5'b01000;
    localparam logic [4:0] OpStore = 5'b01001;
    localparam logic [4:0] OpBeq   = 5'b01010;
    localparam logic [4:0] OpBne   = 5'b01011;
    localparam logic [4:0] OpJump  = 5'b01100;
    localparam logic [4:0] OpHalt  = 5'b11111;

    state_e     state_q, state_d;
    logic [4:0] opcode_q, opcode_d;
    logic       illegal_q, illegal_d;

    // Overflow is handled in the datapath; the sequence never looks at it.
    logic unused_overflow;
    assign unused_overflow = Overflow;

    // State, captured opcode and illegal flag registers with synchronous reset.
    always_ff @(posedge CLK) begin
        if (Reset) begin
            state_q   <= StFetch;
            opcode_q  <= 5'd0;
            illegal_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            opcode_q  <= opcode_d;
            illegal_q <= illegal_d;
        end
    end

    // Next-state logic; the opcode is captured in DECODE for later dispatch.
    always_comb begin
        state_d   = StFetch;
        opcode_d  = opcode_q;
        illegal_d = illegal_q;
        case (state_q)
            StFetch:   state_d = StDecode;
            StDecode: begin
                opcode_d = Opcode;
                if (Opcode[4:3] == 2'b00) begin
                    state_d = StAluExec;
                end else if (Opcode == OpLoad || Opcode == OpStore) begin
                    state_d = StMemAddr;
                end else if (Opcode == OpBeq || Opcode == OpBne) begin
                    state_d = StBranch;
                end else if (Opcode == OpJump) begin
                    state_d = StJump;
                end else if (Opcode == OpHalt) begin
                    state_d = StHalt;
                end else begin
`ifdef CTRL_ILLEGAL_TRAP_EN
                    state_d   = StHalt;
                    illegal_d = 1'b1;
`else
                    state_d   = StFetch;
`endif
                end
            end
            StAluExec: state_d = StAluWb;
            StAluWb:   state_d = StFetch;
            StMemAddr: state_d = (opcode_q == OpStore) ? StMemWr : StMemRd;
            StMemRd:   state_d = StMemWb;
            StMemWb:   state_d = StFetch;
            StMemWr:   state_d = StFetch;
            StBranch:  state_d = StFetch;
            StJump:    state_d = StFetch;
            StHalt:    state_d = StHalt;
            default:   state_d = StFetch;
        endcase
    end

    // Moore output decode from the registered state (and captured opcode) only.
    always_comb begin
        ALUOp        = 2'b00;
        ALUSrcA      = 2'b00;
        ALUSrcB      = 2'b00;
        MemtoReg     = 2'b00;
        RegWrite     = 1'b0;
        MemRead      = 1'b0;
        MemWrite     = 1'b0;
        IorD         = 2'b00;
        IRWrite      = 1'b0;
        PCWrite      = 1'b0;
        Jump         = 1'b0;
        Branch       = 2'b00;
        shouldBranch = 1'b0;
        RegFileSrc   = 2'b00;
        ReturnSrc    = 3'b000;
        DataSrc      = 2'b00;
        OperandSrc   = 2'b00;
        SPWrite      = 1'b0;
        Halted       = 1'b0;
        case (state_q)
            StFetch: begin
                MemRead = 1'b1;
                IRWrite = 1'b1;
                ALUSrcB = 2'b01;
                PCWrite = 1'b1;
            end
            StDecode:  ALUSrcB = 2'b11;
            StAluExec: begin
                ALUSrcA = 2'b01;
                ALUOp   = 2'b10;
            end
            StAluWb:   RegWrite = 1'b1;
            StMemAddr: begin
                ALUSrcA = 2'b01;
                ALUSrcB = 2'b11;
            end
            StMemRd: begin
                MemRead = 1'b1;
                IorD    = 2'b01;
            end
            StMemWb: begin
                RegWrite = 1'b1;
                MemtoReg = 2'b01;
            end
            StMemWr: begin
                MemWrite = 1'b1;
                IorD     = 2'b01;
                DataSrc  = 2'b01;
            end
            StBranch: begin
                ALUSrcA      = 2'b01;
                ALUOp        = 2'b01;
                shouldBranch = 1'b1;
                Branch       = (opcode_q == OpBeq) ? 2'b01 : 2'b10;
            end
            StJump: begin
                Jump    = 1'b1;
                PCWrite = 1'b1;
            end
            StHalt:    Halted = 1'b1;
            default:   ;
        endcase
    end

    assign State = state_q;
`ifdef CTRL_ILLEGAL_TRAP_EN
    assign IllegalOp = illegal_q;
`endif

endmodule

// File: tb/tb_control_unit_fsm.sv
// tb_control_unit_fsm: scoreboard bench. Expected per-cycle state/output records are
// queued when an instruction is launched and compared cycle by cycle at the falling edge.
module tb_control_unit_fsm;

    logic       CLK = 1'b0;
    logic       Reset = 1'b1;
    logic [4:0] Opcode = 5'd0;
    logic       Overflow = 1'b0;
    logic [1:0] ALUOp, ALUSrcA, ALUSrcB, MemtoReg, IorD, Branch, RegFileSrc, DataSrc, OperandSrc;
    logic       RegWrite, MemRead, MemWrite, IRWrite, PCWrite, Jump, shouldBranch, SPWrite;
    logic [2:0] ReturnSrc;
    logic [3:0] State;
    logic       Halted;
`ifdef CTRL_ILLEGAL_TRAP_EN
    logic       IllegalOp;
`endif

    control_unit_fsm dut (
        .CLK(CLK), .Reset(Reset), .Opcode(Opcode), .Overflow(Overflow),
        .ALUOp(ALUOp), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .MemtoReg(MemtoReg),
        .RegWrite(RegWrite), .MemRead(MemRead), .MemWrite(MemWrite), .IorD(IorD),
        .IRWrite(IRWrite), .PCWrite(PCWrite), .Jump(Jump), .Branch(Branch),
        .shouldBranch(shouldBranch), .RegFileSrc(RegFileSrc), .ReturnSrc(ReturnSrc),
        .DataSrc(DataSrc), .OperandSrc(OperandSrc), .SPWrite(SPWrite),
`ifdef CTRL_ILLEGAL_TRAP_EN
        .IllegalOp(IllegalOp),
`endif
        .State(State), .Halted(Halted)
    );

    always #5 CLK = ~CLK;

    typedef struct packed {
        logic [3:0]  st;
        logic [29:0] vec;
        logic        ill;
    } exp_t;

    exp_t        sb_q[$];
    int          n_tests = 0;
    int          n_fail  = 0;
    logic        exp_ill = 1'b0;
    logic [29:0] obs_vec;

    assign obs_vec = {ALUOp, ALUSrcA, ALUSrcB, MemtoReg, RegWrite, MemRead, MemWrite, IorD,
                      IRWrite, PCWrite, Jump, Branch, shouldBranch, RegFileSrc, ReturnSrc,
                      DataSrc, OperandSrc, SPWrite, Halted};

    // Reference output table, one entry per state, in obs_vec field order.
    function automatic logic [29:0] exp_vec(input logic [3:0] st, input logic [4:0] op);
        logic [1:0] aluop, srca, srcb, m2r, iord, br, rfs, ds, os;
        logic [2:0] rs;
        logic       rw, mr, mw, irw, pcw, j, sb, spw, h;
        aluop = 2'b00; srca = 2'b00; srcb = 2'b00; m2r = 2'b00; iord = 2'b00;
        br = 2'b00; rfs = 2'b00; ds = 2'b00; os = 2'b00; rs = 3'b000;
        rw = 1'b0; mr = 1'b0; mw = 1'b0; irw = 1'b0; pcw = 1'b0; j = 1'b0;
        sb = 1'b0; spw = 1'b0; h = 1'b0;
        case (st)
            4'd0:  begin mr = 1'b1; irw = 1'b1; srcb = 2'b01; pcw = 1'b1; end
            4'd1:  srcb = 2'b11;
            4'd2:  begin srca = 2'b01; aluop = 2'b10; end
            4'd3:  rw = 1'b1;
            4'd4:  begin srca = 2'b01; srcb = 2'b11; end
            4'd5:  begin mr = 1'b1; iord = 2'b01; end
            4'd6:  begin rw = 1'b1; m2r = 2'b01; end
            4'd7:  begin mw = 1'b1; iord = 2'b01; ds = 2'b01; end
            4'd8:  begin
                srca = 2'b01; aluop = 2'b01; sb = 1'b1;
                br = (op == 5'b01010) ? 2'b01 : 2'b10;
            end
            4'd9:  begin j = 1'b1; pcw = 1'b1; end
            4'd10: h = 1'b1;
            default: ;
        endcase
        return {aluop, srca, srcb, m2r, rw, mr, mw, iord, irw, pcw, j, br, sb, rfs, rs,
                ds, os, spw, h};
    endfunction

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic push_st(input logic [3:0] st, input logic [4:0] op);
        exp_t e;
        e.st  = st;
        e.vec = exp_vec(st, op);
        e.ill = exp_ill;
        sb_q.push_back(e);
    endtask

    // Compare one queued record per cycle, then advance to the next falling edge.
    task automatic drain(input string tag);
        exp_t e;
        int   idx;
        idx = 0;
        while (sb_q.size() > 0) begin
            e = sb_q.pop_front();
            check_eq($sformatf("%s[%0d].state", tag, idx), {28'd0, State}, {28'd0, e.st});
            check_eq($sformatf("%s[%0d].outs", tag, idx), {2'd0, obs_vec}, {2'd0, e.vec});
`ifdef CTRL_ILLEGAL_TRAP_EN
            check_eq($sformatf("%s[%0d].illegal", tag, idx), {31'd0, IllegalOp},
                     {31'd0, e.ill});
`endif
            idx++;
            @(posedge CLK);
            @(negedge CLK);
        end
    endtask

    task automatic do_reset();
        Reset = 1'b1;
        @(posedge CLK);
        @(negedge CLK);
        Reset   = 1'b0;
        exp_ill = 1'b0;
    endtask

    task automatic run_seq(input string tag, input logic [4:0] op, input logic [3:0] s2,
                           input logic [3:0] s3, input logic [3:0] s4, input int len);
        Opcode = op;
        push_st(4'd0, op);
        push_st(4'd1, op);
        if (len > 2) push_st(s2, op);
        if (len > 3) push_st(s3, op);
        if (len > 4) push_st(s4, op);
        drain(tag);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        @(posedge CLK);
        @(negedge CLK);
        do_reset();

        run_seq("alu", 5'b00011, 4'd2, 4'd3, 4'd0, 4);
        Overflow = 1'b1;
        run_seq("alu_ovf", 5'b00111, 4'd2, 4'd3, 4'd0, 4);
        Overflow = 1'b0;
        run_seq("load", 5'b01000, 4'd4, 4'd5, 4'd6, 5);
        run_seq("store", 5'b01001, 4'd4, 4'd7, 4'd0, 4);
        run_seq("bne", 5'b01011, 4'd8, 4'd0, 4'd0, 3);
        run_seq("beq", 5'b01010, 4'd8, 4'd0, 4'd0, 3);
        run_seq("jump", 5'b01100, 4'd9, 4'd0, 4'd0, 3);

`ifdef CTRL_ILLEGAL_TRAP_EN
        Opcode = 5'b10101;
        push_st(4'd0, Opcode);
        push_st(4'd1, Opcode);
        exp_ill = 1'b1;
        for (int i = 0; i < 5; i++) push_st(4'd10, Opcode);
        drain("illegal_trap");
        do_reset();
`else
        run_seq("illegal_nop", 5'b10101, 4'd0, 4'd0, 4'd0, 2);
`endif

        // Reset while in MEM_RD must land in FETCH on the next edge.
        Opcode = 5'b01000;
        push_st(4'd0, Opcode);
        push_st(4'd1, Opcode);
        push_st(4'd4, Opcode);
        drain("load_pre_rst");
        check_eq("in_mem_rd", {28'd0, State}, 32'd5);
        do_reset();
        run_seq("after_rst", 5'b00001, 4'd2, 4'd3, 4'd0, 4);

        // HALT holds for 20 cycles, only Reset leaves it.
        Opcode = 5'b11111;
        push_st(4'd0, Opcode);
        push_st(4'd1, Opcode);
        for (int i = 0; i < 20; i++) push_st(4'd10, Opcode);
        drain("halt");
        check_eq("halt_held", {28'd0, State}, 32'd10);
        do_reset();
        push_st(4'd0, 5'b00000);
        drain("post_halt_rst");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
